// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the MIPS pipeline.
//   INSTR_NOP, RESET_PC_DEFAULT, counter saturation value, opcode/funct
//   constants, and the j-instruction target helper.
package mips_pkg;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PERF_CNT_MAX     = 32'hFFFF_FFFF;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // j target: region bits come from the PC+4 of the jump itself.
  function automatic logic [31:0] jump_target(input logic [3:0]  pc4_hi,
                                              input logic [25:0] idx);
    return {pc4_hi, idx, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_perf_ctr.sv
// fetch_perf_ctr: 32-bit saturating event counter with synchronous
// active-low clear.
//   clk    in   clock
//   rst_n  in   synchronous clear, active-low
//   i_inc  in   count one event this cycle
//   o_cnt  out  current count (sticks at all-ones)
module fetch_perf_ctr
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc,
  output logic [31:0] o_cnt
);

  logic [31:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != PERF_CNT_MAX)) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage of the 5-stage MIPS pipeline.
//   Holds the PC, addresses IMEM (combinational read), captures the returned
//   word into the IF/ID register, and applies stall / branch / jump redirects.
//   Optional feature macro: FETCH_PERF_EN adds stall_cnt / flush_cnt ports.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   imem_addr  out  ADDR_W      byte address = pc[ADDR_W-1:0]
//   imem_data  in   32          instruction word for imem_addr
//   stall      in   1           hold PC and IF/ID
//   id_branch_taken/target      taken beq redirect
//   id_jump/id_jump_idx         j redirect
//   pc         out  32          current fetch PC
//   if_id_instr/pc4/valid       IF/ID register
//   stall_cnt/flush_cnt (opt)   saturating perf counters
module fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned  ADDR_W   = 7,
  parameter logic [31:0]  RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              stall,
  input  logic              id_branch_taken,
  input  logic [31:0]       id_branch_target,
  input  logic              id_jump,
  input  logic [25:0]       id_jump_idx,
  output logic [31:0]       pc,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       if_id_pc4,
  output logic              if_id_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  logic [31:0] r_pc;
  logic [31:0] r_if_id_instr;
  logic [31:0] r_if_id_pc4;
  logic        r_if_id_valid;

  logic [31:0] w_pc4;
  logic [31:0] w_branch_tgt;
  logic        w_redirect;
  logic [31:0] w_pc_next;

  assign w_pc4        = r_pc + 32'd4;
  assign w_branch_tgt = id_branch_target & ~32'h3;
  assign w_redirect   = id_branch_taken | id_jump;

  // Branch beats jump; any redirect beats stall.
  always_comb begin
    w_pc_next = w_pc4;
    if (id_branch_taken) begin
      w_pc_next = w_branch_tgt;
    end else if (id_jump) begin
      w_pc_next = jump_target(r_if_id_pc4[31:28], id_jump_idx);
    end else if (stall) begin
      w_pc_next = r_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_if_id_instr <= INSTR_NOP;
      r_if_id_pc4   <= '0;
      r_if_id_valid <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_redirect) begin
        // Squash the wrong-path fetch; pc4 is left as-is.
        r_if_id_instr <= INSTR_NOP;
        r_if_id_valid <= 1'b0;
      end else if (!stall) begin
        r_if_id_instr <= imem_data;
        r_if_id_pc4   <= w_pc4;
        r_if_id_valid <= 1'b1;
      end
    end
  end

  assign imem_addr   = r_pc[ADDR_W-1:0];
  assign pc          = r_pc;
  assign if_id_instr = r_if_id_instr;
  assign if_id_pc4   = r_if_id_pc4;
  assign if_id_valid = r_if_id_valid;

`ifdef FETCH_PERF_EN
  fetch_perf_ctr u_stall_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (stall & ~w_redirect),
    .o_cnt (stall_cnt)
  );

  fetch_perf_ctr u_flush_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_redirect),
    .o_cnt (flush_cnt)
  );
`endif

`ifndef SYNTHESIS
  // ID must never raise both redirects; branch is honoured if it does.
  always @(posedge clk) begin
    if (rst_n && id_branch_taken && id_jump) begin
      $warning("fetch_unit: protocol violation, branch and jump in same cycle");
    end
  end
`endif

endmodule
